mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Round-robin arbiter that shares one memory port between three requesters: 0 = instruction fetch, 1 = data load/store, 2 = auxiliary (debug/DMA).
- Drives the 2-bit select of the 3:1 32-bit address/data mux in front of the memory, plus the port's valid strobe.
- Holds each grant until the memory acknowledges or a watchdog timeout aborts the transaction.
- Sits between the control unit/fetch logic and the shared memory port.

Parameters:
- MAX_WAIT, 16, max cycles a grant waits for mem_ready before abort. 0 disables the timeout.
- CNT_W, 5, width of the wait counter. Must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req  input  3  request per requester; bit i = requester i
- mem_ready  input  1  memory completes the current transaction this cycle
- gnt  output  3  one-hot grant, registered
- sel  output  2  mux select, registered: 2'b00 = req0, 2'b01 = req1, 2'b10 = req2. 2'b11 is never driven.
- mem_valid  output  1  transaction active on the port; equals |gnt
- done  output  3  one-cycle pulse on bit i when requester i's transaction completes
- timeout  output  1  one-cycle pulse when a grant is aborted by the watchdog

Behaviour:
- The one clock is clk. Reset is synchronous and active-high on reset. Both are fixed.
- Reset values: gnt=000, sel=00, mem_valid=0, done=000, timeout=0, wait_cnt=0, last=2 (so requester 0 wins first), state=IDLE.
- States:
  - IDLE: no grant. If any req bit is set, pick a winner; next cycle gnt/sel/mem_valid assert and state becomes BUSY. No req: stay in IDLE, outputs 0.
  - BUSY: grant held constant. wait_cnt increments each cycle mem_ready=0.
- Winner selection: search order starts at (last+1) mod 3 and wraps, e.g. last=0 gives order 1, 2, 0. The winner index is stored in last when granted.
- Completion: in BUSY with mem_ready=1:
  - done[winner]=1 next cycle; wait_cnt cleared.
  - If any req is set that same cycle (including the same requester), re-arbitrate with the updated last and grant next cycle back-to-back, staying in BUSY.
  - Otherwise go to IDLE.
- Timeout: MAX_WAIT>0, BUSY, mem_ready=0 and wait_cnt==MAX_WAIT-1:
  - Next cycle: grant dropped, timeout=1, done=000, wait_cnt=0, state IDLE.
  - last keeps the aborted requester, so it loses priority.
- mem_ready=1 on the timeout cycle counts as completion; it takes precedence over timeout.
- mem_ready while in IDLE is ignored.
- Requester dropping req while granted is ignored; the grant holds until completion or timeout.
- New requests arriving mid-BUSY wait; no preemption.
- Reset asserted mid-transaction: all outputs go to reset values next edge; no done or timeout pulse is emitted.
- Latency: request in IDLE to grant = 1 cycle. mem_ready to done / next grant = 1 cycle. Throughput is 1 transaction per cycle when memory is single-cycle.
- Invariants: gnt is always one-hot or zero; sel encodes gnt; mem_valid == |gnt.

Decomposition:
- Shared package (constants in the processor include file): REQ_IFETCH=2'd0, REQ_DATA=2'd1, REQ_AUX=2'd2, SEL_NONE default 2'b00, state encodings ST_IDLE/ST_BUSY.
- One natural sub-module, rr_pick3: combinational; inputs req[2:0] and last[1:0]; outputs valid and winner[1:0]. Used in both IDLE and completion paths.
- Counter and FSM stay in the top.

Test Plan:
- Reset then req=001, mem_ready=1 one cycle after grant: gnt=001, sel=00, mem_valid=1 one cycle after req; done=001 the cycle after mem_ready; back to IDLE with gnt=000.
- req=111 held, mem_ready=1 every BUSY cycle: grant sequence 001, 010, 100, 001 back-to-back; sel 00, 01, 10, 00; no idle bubbles.
- req=011, mem_ready held 0, MAX_WAIT=4: grant 001 for 4 cycles, then timeout=1 pulse and gnt=000; next grant is 010 (last=0), and done never pulses for the aborted requester.
- Grant to req1; req1 drops to 0 after 1 cycle; mem_ready after 3 cycles: gnt=010 held all 3 cycles; done=010 afterwards.
- mem_ready=1 on exact timeout cycle (wait_cnt=MAX_WAIT-1): done pulses, timeout stays 0.
- Reset asserted during BUSY with gnt=100: next cycle gnt=000, sel=00, done=000, timeout=0; after release with req=111, first grant is 001.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the three-way memory port arbiter: requester ids,
// select encodings, FSM state encodings and a small one-hot helper.
package mem_port_arbiter_pkg;

  localparam logic [1:0] REQ_IFETCH = 2'd0;
  localparam logic [1:0] REQ_DATA   = 2'd1;
  localparam logic [1:0] REQ_AUX    = 2'd2;
  localparam logic [1:0] SEL_NONE   = 2'b00;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      REQ_IFETCH: oh = 3'b001;
      REQ_DATA:   oh = 3'b010;
      REQ_AUX:    oh = 3'b100;
      default:    oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick3.sv
// Combinational round-robin picker: searches requesters starting just after
// the last winner, wrapping modulo 3.
module rr_pick3
  import mem_port_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] winner
);

  // Priority rotation keyed on the previous winner
  always_comb begin
    valid  = |req;
    winner = REQ_IFETCH;
    case (last)
      REQ_IFETCH: begin
        if (req[1])      winner = REQ_DATA;
        else if (req[2]) winner = REQ_AUX;
        else             winner = REQ_IFETCH;
      end
      REQ_DATA: begin
        if (req[2])      winner = REQ_AUX;
        else if (req[0]) winner = REQ_IFETCH;
        else if (req[1]) winner = REQ_DATA;
        else             winner = REQ_IFETCH;
      end
      default: begin
        if (req[0])      winner = REQ_IFETCH;
        else if (req[1]) winner = REQ_DATA;
        else if (req[2]) winner = REQ_AUX;
        else             winner = REQ_IFETCH;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among fetch, data and aux
// requesters; grants are held until mem_ready or a watchdog abort.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic       mem_ready,
  output logic [2:0] gnt,
  output logic [1:0] sel,
  output logic       mem_valid,
  output logic [2:0] done,
  output logic       timeout
);

  localparam bit             TO_EN     = (MAX_WAIT > 0);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MAX_WAIT > 0) ? (MAX_WAIT - 1) : 0);

  logic [0:0]       state_r;
  logic [1:0]       last_r;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             pick_valid_s;
  logic [1:0]       pick_winner_s;

  rr_pick3 u_pick (
    .req    (req),
    .last   (last_r),
    .valid  (pick_valid_s),
    .winner (pick_winner_s)
  );

  // Arbitration FSM, watchdog counter and registered port outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      last_r     <= REQ_AUX;
      wait_cnt_r <= '0;
      gnt        <= 3'b000;
      sel        <= SEL_NONE;
      mem_valid  <= 1'b0;
      done       <= 3'b000;
      timeout    <= 1'b0;
    end else begin
      done    <= 3'b000;
      timeout <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          wait_cnt_r <= '0;
          if (pick_valid_s) begin
            gnt       <= onehot3(pick_winner_s);
            sel       <= pick_winner_s;
            mem_valid <= 1'b1;
            last_r    <= pick_winner_s;
            state_r   <= ST_BUSY;
          end else begin
            gnt       <= 3'b000;
            sel       <= SEL_NONE;
            mem_valid <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (mem_ready) begin
            // Completion wins over a coincident watchdog expiry
            done       <= gnt;
            wait_cnt_r <= '0;
            if (pick_valid_s) begin
              gnt       <= onehot3(pick_winner_s);
              sel       <= pick_winner_s;
              mem_valid <= 1'b1;
              last_r    <= pick_winner_s;
            end else begin
              gnt       <= 3'b000;
              sel       <= SEL_NONE;
              mem_valid <= 1'b0;
              state_r   <= ST_IDLE;
            end
          end else if (TO_EN && (wait_cnt_r == WAIT_LAST)) begin
            gnt        <= 3'b000;
            sel        <= SEL_NONE;
            mem_valid  <= 1'b0;
            timeout    <= 1'b1;
            wait_cnt_r <= '0;
            state_r    <= ST_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          wait_cnt_r <= '0;
          gnt        <= 3'b000;
          sel        <= SEL_NONE;
          mem_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule
